sq_accumulator: RTL

//  Downstream consumer of the 4-bit squarer's 8-bit product p[7:0]. Accumulates
//  N consecutive squares into one frame sum (sum of squares / energy). Input side
//  is a valid/ready stream; the result is held on a valid/ready output until taken.

---
 rtl/sq_accumulator.sv | 86 ++++++++
 1 files changed

// File: rtl/sq_accumulator.sv
// Frame energy accumulator: sums N consecutive squares from the squarer stream
// and holds each frame sum on a valid/ready output until downstream takes it.
module sq_accumulator #(
  parameter int SQ_W  = 8,
  parameter int N     = 16,
  parameter int ACC_W = 12   // must cover SQ_W + clog2(N) so the frame sum never wraps
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SQ_W-1:0]  i_sq_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [ACC_W-1:0] o_sum_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_frame_idx
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic             r_out_valid;
  logic [7:0]       r_frame_idx;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_last;
  logic [ACC_W-1:0] w_acc_add;

  // Ready depends on state (and reset) only, never on the handshake inputs.
  assign o_in_ready = (r_state == ACCUM) && !i_rst;
  assign w_in_xfer  = i_in_valid && o_in_ready;
  assign w_out_xfer = r_out_valid && i_out_ready;
  assign w_last     = (r_frame_idx == LAST_IDX);
  assign w_acc_add  = r_acc + ACC_W'(i_sq_in);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_in_xfer && w_last) w_state_nxt = HOLD;
      HOLD:    if (w_out_xfer)          w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Input transfers only happen in ACCUM and output hand-off only in HOLD,
  // so the two branches below are mutually exclusive.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_frame_idx <= '0;
    end else if (w_in_xfer) begin
      if (w_last) begin
        r_sum       <= w_acc_add;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_frame_idx <= '0;
      end else begin
        r_acc       <= w_acc_add;
        r_frame_idx <= r_frame_idx + 8'd1;
      end
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_sum_out   = r_sum;
  assign o_out_valid = r_out_valid;
  assign o_frame_idx = r_frame_idx;

endmodule
